seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
Reader for a time-multiplexed 7-segment display bus: samples the one-hot digit select and active-high segment lines and decodes each settled pattern back to a 4-bit hex nibble. It assembles a DIGITS-wide word and flags blank and undecodable digits. It pulses when every digit has been refreshed. It sits on the display side of the board model, so a bench or self-check path can read back what the scan driver actually shows.

Parameters:
DIGITS, 8, number of multiplexed digits (select width); 1..16
STABLE, 3, consecutive identical samples required before a digit commits; must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sel  input  DIGITS  one-hot digit select; bit i = digit i lit
seg  input  7  segment lines, active-high; bit0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle
value  output  4*DIGITS  decoded nibbles; digit i at [4i+3:4i]
blank  output  DIGITS  digit i last committed as all-segments-off
err  output  DIGITS  digit i last committed with a non-hex pattern
frame_valid  output  1  one-cycle pulse when all digits have committed since the previous pulse
sel_err  output  1  one-cycle pulse for a sample whose sel is not one-hot

Behaviour:
- Reset (rst high at an edge): value = 0, blank = all ones, err = 0, frame_valid = 0, sel_err = 0, held sample = 0, stability count = 0, seen mask = 0. Reset overrides every other event in the same cycle, including a commit.
- Decode table (seg hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
  - 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F.
  - 00 -> blank.
  - Any other pattern -> error.
- Stability filter, evaluated at each edge:
  - If sel is not one-hot (zero bits or more than one bit set): sel_err = 1 for that cycle, count = 0, no commit.
  - Else if (sel, seg) equals the held sample and count > 0: count = count + 1, saturating at STABLE.
  - Else: held sample = (sel, seg), count = 1.
- Commit fires on the edge where the input equals the held sample and count == STABLE-1. It therefore fires once per stable period. With an input held from edge 1, outputs update at edge STABLE.
- On commit to digit i:
  - Valid hex pattern: value nibble i = decoded nibble, blank[i] = 0, err[i] = 0.
  - seg == 00: value nibble i = 0, blank[i] = 1, err[i] = 0.
  - Invalid pattern: value nibble i = 0, blank[i] = 0, err[i] = 1.
- Frame tracking:
  - On each commit, next_seen = seen | sel.
  - If next_seen is all ones: frame_valid = 1 on that same edge and seen is cleared to 0. Otherwise seen = next_seen.
  - A repeated commit to an already-seen digit updates value but does not advance the frame.
- Glitch rejection: any change of sel or seg before STABLE samples restarts the count. Patterns shorter than STABLE cycles never commit.
- A pattern held indefinitely commits exactly once. It commits again only after a different sample intervenes.
- Reset mid-frame discards the partial seen mask and all partial counts.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
Use DIGITS=4, STABLE=3 for every case.
1. Reset, then hold sel=0001, seg=3F for 3 cycles -> value[3:0]=0 at edge 3, blank=1110, err=0000, frame_valid stays 0.
2. Scan sel=0001/0010/0100/1000 with seg=06/5B/4F/66, each held 3 cycles -> value=16'h4321, blank=0000, frame_valid pulses once on the edge of the digit-3 commit.
3. sel=0010 with seg=77 for 2 cycles, then seg=7C for 3 cycles -> only b commits, value[7:4]=B, and no A commit ever occurs.
4. sel=0100 with seg=7E (invalid) for 3 cycles -> err=0100, value[11:8]=0, blank[2]=0. Then seg=00 for 3 cycles -> err=0000, blank[2]=1.
5. sel=0011 for 1 cycle, then sel=0000 for 1 cycle -> sel_err pulses each cycle, no output changes. Then sel=0001, seg=6F for 3 cycles -> value[3:0]=9.
6. Commit digits 0 and 1, assert rst for 1 cycle, then commit digits 2 and 3 -> no frame_valid. After digits 0 and 1 commit again, frame_valid pulses and all outputs reflect post-reset commits only.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Display-side bus of a multiplexed 7-segment scanner: the raw select/segment
// lines seen by the reader, plus the decoded digit word it produces.
interface seg7_scan_decoder_if #(
   parameter int DIGITS = 8
);
   logic [DIGITS-1:0]   sel;
   logic [6:0]          seg;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   blank;
   logic [DIGITS-1:0]   err;
   logic                frame_valid;
   logic                sel_err;

   modport master (
      output sel,
      output seg,
      input  value,
      input  blank,
      input  err,
      input  frame_valid,
      input  sel_err
   );

   modport slave (
      input  sel,
      input  seg,
      output value,
      output blank,
      output err,
      output frame_valid,
      output sel_err
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a time-multiplexed 7-segment display, debounces each (sel, seg) sample
// and decodes settled digits back to hex nibbles with blank/error flags.
module seg7_scan_decoder #(
   parameter int DIGITS = 8,
   parameter int STABLE = 3
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_decoder_if.slave bus
);

   localparam int CW = $clog2(STABLE + 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(STABLE);
   localparam logic [CW-1:0] COMMIT_AT = CW'(STABLE - 1);
   localparam logic [CW-1:0] COUNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      KIND_HEX   = 2'd0,
      KIND_BLANK = 2'd1,
      KIND_ERR   = 2'd2
   } kind_t;

   // Returns {kind, nibble}; nibble is zero for blank and error patterns.
   function automatic logic [5:0] decode_seg(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'h3F:   r = {KIND_HEX, 4'h0};
         7'h06:   r = {KIND_HEX, 4'h1};
         7'h5B:   r = {KIND_HEX, 4'h2};
         7'h4F:   r = {KIND_HEX, 4'h3};
         7'h66:   r = {KIND_HEX, 4'h4};
         7'h6D:   r = {KIND_HEX, 4'h5};
         7'h7D:   r = {KIND_HEX, 4'h6};
         7'h07:   r = {KIND_HEX, 4'h7};
         7'h7F:   r = {KIND_HEX, 4'h8};
         7'h6F:   r = {KIND_HEX, 4'h9};
         7'h77:   r = {KIND_HEX, 4'hA};
         7'h7C:   r = {KIND_HEX, 4'hB};
         7'h39:   r = {KIND_HEX, 4'hC};
         7'h5E:   r = {KIND_HEX, 4'hD};
         7'h79:   r = {KIND_HEX, 4'hE};
         7'h71:   r = {KIND_HEX, 4'hF};
         7'h00:   r = {KIND_BLANK, 4'h0};
         default: r = {KIND_ERR, 4'h0};
      endcase
      return r;
   endfunction

   logic [DIGITS-1:0]   held_sel;
   logic [6:0]          held_seg;
   logic [CW-1:0]       count;
   logic [DIGITS-1:0]   seen;
   logic [4*DIGITS-1:0] value_q;
   logic [DIGITS-1:0]   blank_q;
   logic [DIGITS-1:0]   err_q;
   logic                frame_q;
   logic                sel_err_q;

   logic [DIGITS-1:0]   held_sel_next;
   logic [6:0]          held_seg_next;
   logic [CW-1:0]       count_next;
   logic [DIGITS-1:0]   seen_next;
   logic [DIGITS-1:0]   seen_or;
   logic [4*DIGITS-1:0] value_next;
   logic [DIGITS-1:0]   blank_next;
   logic [DIGITS-1:0]   err_next;
   logic                frame_next;
   logic                sel_err_next;
   logic                onehot;
   logic                same;
   logic                commit;
   logic [5:0]          dec;
   kind_t               kind;

   // Stability filter, commit decode and frame tracking.
   always_comb begin
      held_sel_next = held_sel;
      held_seg_next = held_seg;
      count_next    = count;
      seen_next     = seen;
      value_next    = value_q;
      blank_next    = blank_q;
      err_next      = err_q;
      frame_next    = 1'b0;
      sel_err_next  = 1'b0;
      commit        = 1'b0;

      onehot  = (bus.sel != {DIGITS{1'b0}}) &&
                ((bus.sel & (bus.sel - {{(DIGITS-1){1'b0}}, 1'b1})) == {DIGITS{1'b0}});
      same    = (bus.sel == held_sel) && (bus.seg == held_seg);
      dec     = decode_seg(bus.seg);
      kind    = kind_t'(dec[5:4]);
      seen_or = seen | bus.sel;

      if (!onehot) begin
         sel_err_next = 1'b1;
         count_next   = {CW{1'b0}};
      end else if (same && (count != {CW{1'b0}})) begin
         commit = (count == COMMIT_AT);
         // Saturation keeps a held pattern from ever hitting COMMIT_AT again.
         if (count != COUNT_MAX) begin
            count_next = count + COUNT_ONE;
         end else begin
            count_next = count;
         end
      end else begin
         held_sel_next = bus.sel;
         held_seg_next = bus.seg;
         count_next    = COUNT_ONE;
      end

      for (int i = 0; i < DIGITS; i++) begin
         if (commit && bus.sel[i]) begin
            value_next[4*i +: 4] = dec[3:0];
            blank_next[i]        = (kind == KIND_BLANK);
            err_next[i]          = (kind == KIND_ERR);
         end else begin
            value_next[4*i +: 4] = value_q[4*i +: 4];
            blank_next[i]        = blank_q[i];
            err_next[i]          = err_q[i];
         end
      end

      if (commit) begin
         if (seen_or == {DIGITS{1'b1}}) begin
            frame_next = 1'b1;
            seen_next  = {DIGITS{1'b0}};
         end else begin
            seen_next  = seen_or;
         end
      end else begin
         seen_next = seen;
      end
   end

   // State and output registers; reset wins over a same-cycle commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         held_sel  <= {DIGITS{1'b0}};
         held_seg  <= 7'h00;
         count     <= {CW{1'b0}};
         seen      <= {DIGITS{1'b0}};
         value_q   <= {(4*DIGITS){1'b0}};
         blank_q   <= {DIGITS{1'b1}};
         err_q     <= {DIGITS{1'b0}};
         frame_q   <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         held_sel  <= held_sel_next;
         held_seg  <= held_seg_next;
         count     <= count_next;
         seen      <= seen_next;
         value_q   <= value_next;
         blank_q   <= blank_next;
         err_q     <= err_next;
         frame_q   <= frame_next;
         sel_err_q <= sel_err_next;
      end
   end

   assign bus.value       = value_q;
   assign bus.blank       = blank_q;
   assign bus.err         = err_q;
   assign bus.frame_valid = frame_q;
   assign bus.sel_err     = sel_err_q;

endmodule
